// File: rtl/wam_pkg.sv
// Shared definitions for the whac-a-mole input front end: repeat FSM state
// codes and the default debounce/repeat timing used by the game core docs.
package wam_pkg;

  // Repeat FSM states for the hardness buttons.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rpt_state_t;

  // Default timing, in clk_19 cycles.
  localparam int DEF_DB_CYC  = 4;
  localparam int DEF_RPT_DLY = 48;
  localparam int DEF_RPT_PER = 12;

endpackage

// File: rtl/wam_deb.sv
// One input channel: 2-flop synchroniser, counter debounce and a registered
// rising-edge pulse. The delayed stable level is exported aligned with the
// pulse so downstream logic sees "pressed" and "just pressed" in one cycle.
module wam_deb import wam_pkg::*; #(
  parameter int DB_CYC = DEF_DB_CYC,
  parameter int CW     = 6
) (
  input  logic clk_19,
  input  logic rst,
  input  logic raw,
  output logic held,
  output logic rise
);

  localparam logic [CW-1:0] CNT_END = CW'(DB_CYC - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          stab;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser on the asynchronous raw input.
  always_ff @(posedge clk_19) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after it has been seen for DB_CYC cycles in a row.
  always_ff @(posedge clk_19) begin
    if (rst) begin
      stab <= 1'b0;
      cnt  <= '0;
    end else if (sync_p1 == stab) begin
      cnt <= '0;
    end else if (cnt == CNT_END) begin
      stab <= sync_p1;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delay the stable level one cycle and flag its 0->1 transition.
  always_ff @(posedge clk_19) begin
    if (rst) begin
      held <= 1'b0;
      rise <= 1'b0;
    end else begin
      held <= stab;
      rise <= stab & ~held;
    end
  end

endmodule

// File: rtl/wam_btn.sv
// Input front end of the whac-a-mole board: debounced hole taps plus
// left/right hardness buttons with hold-to-repeat, and an activity strobe
// for the digit flash.
module wam_btn import wam_pkg::*; #(
  parameter int N_HOLE  = 8,
  parameter int DB_CYC  = DEF_DB_CYC,
  parameter int RPT_DLY = DEF_RPT_DLY,
  parameter int RPT_PER = DEF_RPT_PER,
  parameter int CW      = 6
) (
  input  logic              clk_19,
  input  logic              rst,
  input  logic [N_HOLE-1:0] sw,
  input  logic              btnl,
  input  logic              btnr,
  output logic [N_HOLE-1:0] tap,
  output logic              lft,
  output logic              rgt,
  output logic              act
);

  localparam int            N_CH    = N_HOLE + 2;
  localparam logic [CW-1:0] DLY_END = CW'(RPT_DLY - 1);
  localparam logic [CW-1:0] PER_END = CW'(RPT_PER - 1);

  logic [N_CH-1:0] raw_v;
  logic [N_CH-1:0] held_v;
  logic [N_CH-1:0] rise_v;

  // Channel order: holes in the low bits, then left, then right button.
  assign raw_v = {btnr, btnl, sw};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    wam_deb #(
      .DB_CYC (DB_CYC),
      .CW     (CW)
    ) u_deb (
      .clk_19 (clk_19),
      .rst    (rst),
      .raw    (raw_v[g]),
      .held   (held_v[g]),
      .rise   (rise_v[g])
    );
  end

  // Hole levels are only needed as edge history inside each channel.
  logic unused_hole_held;
  assign unused_hole_held = ^held_v[N_HOLE-1:0];

  assign tap = rise_v[N_HOLE-1:0];

  // Index 0 is the left button, index 1 the right button.
  logic [1:0]    btn_held;
  logic [1:0]    btn_rise;
  logic          both;
  rpt_state_t    state_q [2];
  rpt_state_t    state_d [2];
  logic [CW-1:0] r_q [2];
  logic [CW-1:0] r_d [2];
  logic [1:0]    pulse;

  assign btn_held = held_v[N_HOLE +: 2];
  assign btn_rise = rise_v[N_HOLE +: 2];
  assign both     = &btn_held;

  // Repeat FSM state and counter registers for both buttons.
  always_ff @(posedge clk_19) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= IDLE;
        r_q[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= state_d[k];
        r_q[k]     <= r_d[k];
      end
    end
  end

  // Next state and pulses. Holding both buttons parks both FSMs in IDLE with
  // the counter cleared, so the survivor of a release restarts its full
  // initial delay from HOLD; press pulses stay live throughout.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      r_d[k]     = r_q[k];
      pulse[k]   = 1'b0;
      if (!btn_held[k]) begin
        state_d[k] = IDLE;
        r_d[k]     = '0;
      end else if (both) begin
        state_d[k] = IDLE;
        r_d[k]     = '0;
        pulse[k]   = btn_rise[k];
      end else begin
        case (state_q[k])
          IDLE: begin
            state_d[k] = HOLD;
            r_d[k]     = '0;
            pulse[k]   = btn_rise[k];
          end
          HOLD: begin
            if (r_q[k] == DLY_END) begin
              state_d[k] = RPT;
              r_d[k]     = '0;
              pulse[k]   = 1'b1;
            end else begin
              r_d[k] = r_q[k] + 1'b1;
            end
          end
          RPT: begin
            if (r_q[k] == PER_END) begin
              r_d[k]   = '0;
              pulse[k] = 1'b1;
            end else begin
              r_d[k] = r_q[k] + 1'b1;
            end
          end
          default: begin
            state_d[k] = IDLE;
            r_d[k]     = '0;
          end
        endcase
      end
    end
  end

  assign lft = pulse[0];
  assign rgt = pulse[1];

  // Activity strobe one cycle after any tap or hardness pulse.
  always_ff @(posedge clk_19) begin
    if (rst) begin
      act <= 1'b0;
    end else begin
      act <= (|tap) | lft | rgt;
    end
  end

endmodule

// File: tb/tb_wam_btn.sv
// Directed bench for wam_btn with default timing (DB_CYC=4, RPT_DLY=48,
// RPT_PER=12). Expected pulses are hand-computed per cycle; act is expected
// to echo the previous cycle's expected pulses.
module tb_wam_btn;

  logic       clk_19;
  logic       rst;
  logic [7:0] sw;
  logic       btnl;
  logic       btnr;
  logic [7:0] tap;
  logic       lft;
  logic       rgt;
  logic       act;

  int n_chk  = 0;
  int n_pass = 0;
  logic prev_any = 1'b0;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] tap;
  } vec_t;

  vec_t tbl [46];

  wam_btn dut (
    .clk_19 (clk_19),
    .rst    (rst),
    .sw     (sw),
    .btnl   (btnl),
    .btnr   (btnr),
    .tap    (tap),
    .lft    (lft),
    .rgt    (rgt),
    .act    (act)
  );

  initial clk_19 = 1'b0;
  always #5 clk_19 = ~clk_19;

  task automatic chk(input string name, input int idx,
                     input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0d got=%0h want=%0h", name, idx, got, want);
  endtask

  // Advance one edge, then compare all outputs against the expected pulses.
  task automatic run_cycle(input string name, input int idx,
                           input logic [7:0] etap, input logic el, input logic er);
    logic eact;
    @(posedge clk_19);
    #1;
    eact = prev_any;
    chk({name, ".tap"}, idx, tap, etap);
    chk({name, ".lft"}, idx, {7'd0, lft}, {7'd0, el});
    chk({name, ".rgt"}, idx, {7'd0, rgt}, {7'd0, er});
    chk({name, ".act"}, idx, {7'd0, act}, {7'd0, eact});
    prev_any = (|etap) | el | er;
  endtask

  initial begin
    rst  = 1'b1;
    sw   = 8'hFF;
    btnl = 1'b0;
    btnr = 1'b0;

    // Reset with all holes pressed: everything quiet while rst is high.
    for (int i = 0; i < 3; i++) run_cycle("rst", i, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    // Held switches appear as one fresh press.
    for (int i = 0; i < 10; i++)
      run_cycle("rst_rel", i, (i == 6) ? 8'hFF : 8'h00, 1'b0, 1'b0);
    sw = 8'h00;
    for (int i = 0; i < 15; i++) run_cycle("rst_idle", i, 8'h00, 1'b0, 1'b0);

    // Table: simultaneous sw[0]/sw[7] press, 3-cycle glitch, 4-cycle pulse.
    for (int i = 0; i < 46; i++) begin
      tbl[i].sw  = (i < 10) ? 8'h81 :
                   (i >= 20 && i < 23) ? 8'h20 :
                   (i >= 32 && i < 36) ? 8'h20 : 8'h00;
      tbl[i].tap = (i == 6) ? 8'h81 : (i == 38) ? 8'h20 : 8'h00;
    end
    for (int i = 0; i < 46; i++) begin
      sw = tbl[i].sw;
      run_cycle("tbl", i, tbl[i].tap, 1'b0, 1'b0);
    end

    // Bounce on sw[3]: 1,0,1,0 then held 100 cycles, then released.
    for (int i = 0; i < 120; i++) begin
      sw = (i == 1 || i == 3 || i >= 104) ? 8'h00 : 8'h08;
      run_cycle("bounce", i, (i == 10) ? 8'h08 : 8'h00, 1'b0, 1'b0);
    end

    // Right button held 80 cycles: press, first repeat, then periodic repeats.
    for (int i = 0; i < 100; i++) begin
      btnr = (i < 80);
      run_cycle("rpt", i, 8'h00, 1'b0,
                (i == 6 || i == 54 || i == 66 || i == 78));
    end

    // Both held: press pulses only; right release restarts left's delay.
    for (int i = 0; i < 200; i++) begin
      btnl = (i < 171);
      btnr = (i >= 10 && i < 110);
      run_cycle("both", i, 8'h00, (i == 6 || i == 164 || i == 176), (i == 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
